// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding and buffers one instruction for IF/ID.
// Optional feature macro: IFETCH_BUBBLE_FLUSH_EN (flush IF/ID whenever it advances with an empty buffer).
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        ifid_write,
  output logic        ifid_flush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [63:0] pc_r, pc_s;
  logic [63:0] req_pc_r, req_pc_s;
  logic        out_valid_r, out_valid_s;
  logic [63:0] fetch_pc_r, fetch_pc_s;
  logic [31:0] fetch_inst_r, fetch_inst_s;
  logic        imem_req_r, imem_req_s;
  logic [63:0] imem_addr_r, imem_addr_s;

  logic        pc_write_s;
  logic        branch_s;
  logic        consume_s;
  logic        issue_s;
  logic [63:0] target_s;

  // Hazard inputs are ignored while reset is held so IF/ID sees neither write nor flush.
  assign pc_write_s = pc_write & ~reset;
  assign branch_s   = branch_taken & ~reset;
  assign target_s   = {branch_target[63:2], 2'b00};
  assign consume_s  = out_valid_r & pc_write_s & ~branch_s;
  assign issue_s    = (state_r == IDLE) & ~branch_s & (~out_valid_r | consume_s);

  assign ifid_write = consume_s;
`ifdef IFETCH_BUBBLE_FLUSH_EN
  assign ifid_flush = branch_s | (pc_write_s & ~out_valid_r);
`else
  assign ifid_flush = branch_s;
`endif

  assign imem_req   = imem_req_r;
  assign imem_addr  = imem_addr_r;
  assign fetch_pc   = fetch_pc_r;
  assign fetch_inst = fetch_inst_r;

  // Next-state logic: redirect wins over response capture and issue.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    req_pc_s     = req_pc_r;
    out_valid_s  = out_valid_r;
    fetch_pc_s   = fetch_pc_r;
    fetch_inst_s = fetch_inst_r;
    imem_req_s   = 1'b0;
    imem_addr_s  = imem_addr_r;

    if (branch_s) begin
      pc_s        = target_s;
      out_valid_s = 1'b0;
      // An in-flight response must still be swallowed unless it lands this very cycle.
      case (state_r)
        WAIT:    state_s = imem_rvalid ? IDLE : DROP;
        DROP:    state_s = imem_rvalid ? IDLE : DROP;
        default: state_s = IDLE;
      endcase
    end else begin
      if (consume_s) begin
        out_valid_s = 1'b0;
      end else begin
        out_valid_s = out_valid_r;
      end
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            imem_req_s  = 1'b1;
            imem_addr_s = pc_r;
            req_pc_s    = pc_r;
            pc_s        = pc_r + 64'd4;
            state_s     = WAIT;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            fetch_inst_s = imem_rdata;
            fetch_pc_s   = req_pc_r;
            out_valid_s  = 1'b1;
            state_s      = IDLE;
          end else begin
            state_s = WAIT;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state_s = IDLE;
          end else begin
            state_s = DROP;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      req_pc_r     <= RESET_PC;
      out_valid_r  <= 1'b0;
      fetch_pc_r   <= RESET_PC;
      fetch_inst_r <= 32'h0;
      imem_req_r   <= 1'b0;
      imem_addr_r  <= RESET_PC;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_pc_r     <= req_pc_s;
      out_valid_r  <= out_valid_s;
      fetch_pc_r   <= fetch_pc_s;
      fetch_inst_r <= fetch_inst_s;
      imem_req_r   <= imem_req_s;
      imem_addr_r  <= imem_addr_s;
    end
  end

endmodule
